// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches from instruction memory
// over a req/ack handshake, and feeds IF/ID through an output slot backed
// by a one-entry skid buffer. Redirects flush buffered words and discard
// any fetch that is still in flight.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        regReset,
    input  logic [1:0]  bubble,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instru_if,
    output logic [31:0] instru_ifAddress,
    output logic        if_valid
);

    typedef enum logic {
        S_REQ,
        S_WAIT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        discard_q, discard_d;

    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_addr_q, slot_addr_d;

    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_addr_q, skid_addr_d;

    logic        ack_take;
    logic        consume;
    logic        deliver;

    // Next-state logic: redirect first, then fetch sequencing, then slot/skid movement.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        discard_d    = discard_q;
        slot_valid_d = slot_valid_q;
        slot_instr_d = slot_instr_q;
        slot_addr_d  = slot_addr_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_addr_d  = skid_addr_q;
        deliver      = 1'b0;

        // An ack only counts against a request we actually have outstanding.
        ack_take = imem_ack && req_q && (state_q == S_WAIT);
        consume  = (bubble == 2'b00) && slot_valid_q;

        if (redirect_valid) begin
            pc_d         = {redirect_target[31:2], 2'b00};
            slot_valid_d = 1'b0;
            slot_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
            if ((state_q == S_WAIT) && !ack_take) begin
                // Request stays on the bus; its data is thrown away on arrival.
                discard_d = 1'b1;
            end else begin
                state_d   = S_REQ;
                req_d     = 1'b0;
                discard_d = 1'b0;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (!skid_valid_q) begin
                        req_d   = 1'b1;
                        addr_d  = pc_q;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ack_take) begin
                        req_d   = 1'b0;
                        state_d = S_REQ;
                        if (discard_q) begin
                            discard_d = 1'b0;
                        end else begin
                            deliver = 1'b1;
                            pc_d    = pc_q + 32'd4;
                        end
                    end
                end
                default: begin
                    state_d = S_REQ;
                    req_d   = 1'b0;
                end
            endcase

            if (consume) begin
                if (skid_valid_q) begin
                    slot_valid_d = 1'b1;
                    slot_instr_d = skid_instr_q;
                    slot_addr_d  = skid_addr_q;
                    if (deliver) begin
                        skid_valid_d = 1'b1;
                        skid_instr_d = imem_rdata;
                        skid_addr_d  = pc_q;
                    end else begin
                        skid_valid_d = 1'b0;
                    end
                end else if (deliver) begin
                    slot_valid_d = 1'b1;
                    slot_instr_d = imem_rdata;
                    slot_addr_d  = pc_q;
                end else begin
                    slot_valid_d = 1'b0;
                    slot_instr_d = NOP_INSTR;
                end
            end else if (deliver) begin
                if (!slot_valid_q) begin
                    slot_valid_d = 1'b1;
                    slot_instr_d = imem_rdata;
                    slot_addr_d  = pc_q;
                end else begin
                    // Requests stop while the skid is full, so it is empty here.
                    skid_valid_d = 1'b1;
                    skid_instr_d = imem_rdata;
                    skid_addr_d  = pc_q;
                end
            end
        end
    end

    // State and registered outputs, asynchronously cleared by regReset.
    always_ff @(posedge clk or posedge regReset) begin
        if (regReset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            discard_q    <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_instr_q <= NOP_INSTR;
            slot_addr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_addr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            discard_q    <= discard_d;
            slot_valid_q <= slot_valid_d;
            slot_instr_q <= slot_instr_d;
            slot_addr_q  <= slot_addr_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

    assign imem_req         = req_q;
    assign imem_addr        = addr_q;
    assign instru_if        = slot_instr_q;
    assign instru_ifAddress = slot_addr_q;
    assign if_valid         = slot_valid_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios push the words IF/ID
// should latch; a negedge monitor pops and compares on every consumption.
module tb_if_fetch_unit;

    logic        clk;
    logic        regReset;
    logic [1:0]  bubble;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instru_if;
    logic [31:0] instru_ifAddress;
    logic        if_valid;

    int          errors;
    int          checks;
    int          lat;
    logic        extra_ack;
    logic [3:0]  wcnt;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    if_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .NOP_INSTR(32'h0000_0000)
    ) dut (
        .clk             (clk),
        .regReset        (regReset),
        .bubble          (bubble),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .instru_if       (instru_if),
        .instru_ifAddress(instru_ifAddress),
        .if_valid        (if_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory model: ack after 'lat' wait cycles; extra_ack injects a stray ack.
    always @(posedge clk) begin
        if (!imem_req || imem_ack) wcnt <= '0;
        else                       wcnt <= wcnt + 4'd1;
    end
    assign imem_ack   = (imem_req && (int'(wcnt) == lat)) || extra_ack;
    assign imem_rdata = extra_ack ? 32'hBAD0_BAD0 : instr_at(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_q.push_back({instr_at(a), a});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        regReset = 1'b1;
        step(2);
        regReset = 1'b0;
    endtask

    // Monitor: IF/ID latches on negedge when bubble==00 and the slot is valid.
    always @(negedge clk) begin
        if (!regReset && bubble == 2'b00 && if_valid && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %08h@%08h expected none", instru_if, instru_ifAddress);
            end else begin
                e = exp_q.pop_front();
                chk("out_addr", instru_ifAddress, e[31:0]);
                chk("out_instr", instru_if, e[63:32]);
            end
        end
    end

    initial begin
        errors = 0; checks = 0; lat = 0; extra_ack = 1'b0;
        regReset = 1'b1; bubble = 2'b00;
        redirect_valid = 1'b0; redirect_target = '0;
        #2;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_3000);
        chk("rst_instr", instru_if, 32'h0);
        chk("rst_iaddr", instru_ifAddress, 32'h0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);

        // 1: zero-wait streaming
        do_reset();
        push(32'h3000); push(32'h3004); push(32'h3008);
        step(1);
        chk("t1_req0", {31'd0, imem_req}, 32'd1);
        chk("t1_addr0", imem_addr, 32'h3000);
        step(1);
        chk("t1_valid", {31'd0, if_valid}, 32'd1);
        step(1);
        chk("t1_addr1", imem_addr, 32'h3004);
        step(2);
        chk("t1_addr2", imem_addr, 32'h3008);
        step(2);

        // 2: stall fills slot and skid, then drains in order
        bubble = 2'b01;
        do_reset();
        step(6);
        chk("t2_req_held", {31'd0, imem_req}, 32'd0);
        chk("t2_slot", instru_ifAddress, 32'h3000);
        chk("t2_valid", {31'd0, if_valid}, 32'd1);
        push(32'h3000); push(32'h3004); push(32'h3008);
        bubble = 2'b00;
        step(1);
        chk("t2_from_skid", instru_ifAddress, 32'h3004);
        step(3);

        // 3: redirect during a 3-cycle-latency fetch discards the old word
        lat = 3;
        do_reset();
        push(32'h3100);
        step(2);
        redirect_valid = 1'b1; redirect_target = 32'h0000_3100;
        step(1);
        redirect_valid = 1'b0;
        chk("t3_req_held", {31'd0, imem_req}, 32'd1);
        step(2);
        chk("t3_drop_req", {31'd0, imem_req}, 32'd0);
        chk("t3_drop_valid", {31'd0, if_valid}, 32'd0);
        step(1);
        chk("t3_req_tgt", {31'd0, imem_req}, 32'd1);
        chk("t3_addr_tgt", imem_addr, 32'h3100);
        step(4);
        chk("t3_first", instru_ifAddress, 32'h3100);
        step(1);

        // 4: redirect coincident with ack and bubble==00, unaligned target
        lat = 0; bubble = 2'b01;
        do_reset();
        push(32'h3100);
        step(3);
        chk("t4_slot_full", {31'd0, if_valid}, 32'd1);
        bubble = 2'b00; redirect_valid = 1'b1; redirect_target = 32'h0000_3103;
        step(1);
        redirect_valid = 1'b0;
        chk("t4_flush_valid", {31'd0, if_valid}, 32'd0);
        chk("t4_flush_instr", instru_if, 32'h0);
        chk("t4_flush_req", {31'd0, imem_req}, 32'd0);
        step(1);
        chk("t4_addr_tgt", imem_addr, 32'h3100);
        step(2);

        // 5: PC wrap from FFFF_FFFC
        do_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC); push(32'h0000_0000);
        step(1);
        redirect_valid = 1'b0;
        chk("t5_no_req", {31'd0, imem_req}, 32'd0);
        step(1);
        chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        step(2);
        chk("t5_addr_wrap", imem_addr, 32'h0000_0000);
        step(2);

        // 6: async reset mid-transaction with a full slot, then a stray ack
        lat = 2; bubble = 2'b01;
        do_reset();
        step(5);
        chk("t6_pre_req", {31'd0, imem_req}, 32'd1);
        chk("t6_pre_valid", {31'd0, if_valid}, 32'd1);
        regReset = 1'b1;
        #1;
        chk("t6_async_valid", {31'd0, if_valid}, 32'd0);
        chk("t6_async_instr", instru_if, 32'h0);
        chk("t6_async_req", {31'd0, imem_req}, 32'd0);
        chk("t6_async_addr", imem_addr, 32'h3000);
        step(1);
        regReset = 1'b0; extra_ack = 1'b1; bubble = 2'b00;
        step(1);
        extra_ack = 1'b0;
        chk("t6_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t6_restart_addr", imem_addr, 32'h3000);
        chk("t6_late_ack_valid", {31'd0, if_valid}, 32'd0);
        push(32'h3000);
        step(3);
        chk("t6_refetch_valid", {31'd0, if_valid}, 32'd1);
        chk("t6_refetch_addr", instru_ifAddress, 32'h3000);
        step(1);
        regReset = 1'b1;
        step(2);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
